// File: rtl/mm_share_arb.sv
// rtl/mm_share_arb.sv - round-robin share of one pipelined Montgomery multiplier between two requesters
module mm_share_arb #(
   parameter int DW     = 32,
   parameter int MM_LAT = 6,
   parameter int ID_W   = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [DW-1:0]   req_a0,
   input  logic [DW-1:0]   req_b0,
   input  logic [DW-1:0]   req_a1,
   input  logic [DW-1:0]   req_b1,
   input  logic [ID_W-1:0] req_id0,
   input  logic [ID_W-1:0] req_id1,
   output logic [DW-1:0]   mm_in1,
   output logic [DW-1:0]   mm_in2,
   output logic [DW-1:0]   mm_mu,
   output logic [DW-1:0]   mm_p,
   output logic [DW-1:0]   mm__p,
   input  logic [DW-1:0]   mm_out,
   output logic [1:0]      rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic [ID_W-1:0] rsp_id,
   input  logic            cfg_we,
   input  logic [DW-1:0]   cfg_mu,
   input  logic [DW-1:0]   cfg_p,
   input  logic [DW-1:0]   cfg__p,
   output logic            cfg_busy,
   output logic            cfg_done
);

   localparam int DEPTH = MM_LAT + 1;
   localparam int CW    = $clog2(MM_LAT + 3);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD} state_t;

   state_t          r_state;
   logic            r_last;
   logic [DW-1:0]   r_in1, r_in2;
   logic [DW-1:0]   r_mu, r_p, r_np;
   logic [DW-1:0]   r_sh_mu, r_sh_p, r_sh_np;
   logic [CW-1:0]   r_cnt;
   logic            r_tv  [DEPTH];
   logic            r_tr  [DEPTH];
   logic [ID_W-1:0] r_tid [DEPTH];

   logic [1:0]      w_grant;
   logic            w_issue;
   logic            w_sel;
   logic            w_rsp;
   logic [CW-1:0]   w_cnt_next;

   // grant: only in RUN, a same-cycle cfg_we wins; on contention the non-last requester wins
   always_comb begin
      w_grant = 2'b00;
      if (rstn && r_state == S_RUN && !cfg_we) begin
         case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_issue   = |w_grant;
   assign w_sel     = w_grant[1];
   assign req_ready = w_grant;
   assign w_rsp     = r_tv[DEPTH-1];

   // in-flight count after this edge; a simultaneous issue and retire cancel
   always_comb begin
      w_cnt_next = r_cnt;
      case ({w_issue, w_rsp})
         2'b10:   w_cnt_next = r_cnt + CW'(1);
         2'b01:   w_cnt_next = r_cnt - CW'(1);
         default: w_cnt_next = r_cnt;
      endcase
   end

   // operand registers and round-robin pointer move only on a handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_in1  <= '0;
         r_in2  <= '0;
         r_last <= 1'b1;
      end else if (w_issue) begin
         r_in1  <= w_sel ? req_a1 : req_a0;
         r_in2  <= w_sel ? req_b1 : req_b0;
         r_last <= w_sel;
      end
   end

   // tag pipeline mirrors the multiplier latency plus the operand register stage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_tv[k]  <= 1'b0;
            r_tr[k]  <= 1'b0;
            r_tid[k] <= '0;
         end
         r_cnt <= '0;
      end else begin
         r_tv[0]  <= w_issue;
         r_tr[0]  <= w_sel;
         r_tid[0] <= w_sel ? req_id1 : req_id0;
         for (int k = 1; k < DEPTH; k++) begin
            r_tv[k]  <= r_tv[k-1];
            r_tr[k]  <= r_tr[k-1];
            r_tid[k] <= r_tid[k-1];
         end
         r_cnt <= w_cnt_next;
      end
   end

   // constant reload: capture shadows, wait for the pipeline to empty, then swap in one LOAD cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_RUN;
         r_sh_mu <= '0;
         r_sh_p  <= '0;
         r_sh_np <= '0;
         r_mu    <= '0;
         r_p     <= '0;
         r_np    <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (cfg_we) begin
                  r_sh_mu <= cfg_mu;
                  r_sh_p  <= cfg_p;
                  r_sh_np <= cfg__p;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // looking at the next count lets LOAD follow the last result directly
               if (w_cnt_next == '0) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_mu    <= r_sh_mu;
               r_p     <= r_sh_p;
               r_np    <= r_sh_np;
               r_state <= S_RUN;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign mm_in1    = r_in1;
   assign mm_in2    = r_in2;
   assign mm_mu     = r_mu;
   assign mm_p      = r_p;
   assign mm__p     = r_np;
   assign rsp_valid = w_rsp ? (r_tr[DEPTH-1] ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_id    = w_rsp ? r_tid[DEPTH-1] : '0;
   assign rsp_data  = mm_out;
   assign cfg_busy  = (r_state != S_RUN);
   assign cfg_done  = (r_state == S_LOAD);

endmodule

// File: tb/tb_mm_share_arb.sv
// tb/tb_mm_share_arb.sv - self-checking bench for mm_share_arb
module tb_mm_share_arb;
   localparam int DW = 32, MM_LAT = 6, ID_W = 4;

   logic            clk, rstn;
   logic [1:0]      req_valid, req_ready, rsp_valid;
   logic [DW-1:0]   req_a0, req_b0, req_a1, req_b1;
   logic [ID_W-1:0] req_id0, req_id1, rsp_id;
   logic [DW-1:0]   mm_in1, mm_in2, mm_mu, mm_p, mm__p, mm_out, rsp_data;
   logic            cfg_we, cfg_busy, cfg_done;
   logic [DW-1:0]   cfg_mu, cfg_p, cfg__p;

   int n_checks = 0, n_errors = 0, cyc = 0;

   mm_share_arb #(.DW(DW), .MM_LAT(MM_LAT), .ID_W(ID_W)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_id0(req_id0), .req_id1(req_id1), .mm_in1(mm_in1), .mm_in2(mm_in2),
      .mm_mu(mm_mu), .mm_p(mm_p), .mm__p(mm__p), .mm_out(mm_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .cfg_we(cfg_we), .cfg_mu(cfg_mu), .cfg_p(cfg_p), .cfg__p(cfg__p),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // stand-in multiplier: xor of the operands, MM_LAT cycles later
   logic [DW-1:0] mp [MM_LAT];
   always @(posedge clk) begin
      mp[0] <= mm_in1 ^ mm_in2;
      for (int k = 1; k < MM_LAT; k++) mp[k] <= mp[k-1];
   end
   assign mm_out = mp[MM_LAT-1];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: responses due at a fixed cycle, reload done at a computed cycle
   typedef struct { int due; logic req; logic [ID_W-1:0] id; logic [DW-1:0] data; } op_t;
   op_t           exp_q[$];
   bit            m_last, m_cfg;
   int            m_done, m_last_due;
   logic [DW-1:0] m_mu, m_p, m_np, s_mu, s_p, s_np, m_in1, m_in2;

   always @(negedge clk) begin : model
      logic [1:0] eg, er;
      op_t        o;
      if (!rstn) begin
         exp_q.delete();
         m_last = 1; m_cfg = 0; m_last_due = 0; m_done = 0;
         m_mu = 0; m_p = 0; m_np = 0; m_in1 = 0; m_in2 = 0;
         chk("reset_outputs", 256'({req_ready, rsp_valid, cfg_busy, cfg_done, mm_in1, mm_in2, mm_mu, mm_p, mm__p}), 256'(0));
      end else begin
         chk("constants", 256'({mm_mu, mm_p, mm__p}), 256'({m_mu, m_p, m_np}));
         chk("operands", 256'({mm_in1, mm_in2}), 256'({m_in1, m_in2}));
         chk("cfg_busy", 256'(cfg_busy), 256'(m_cfg));
         chk("cfg_done", 256'(cfg_done), 256'(m_cfg && cyc == m_done));
         er = 2'b00;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            o = exp_q.pop_front();
            er = o.req ? 2'b10 : 2'b01;
            chk("rsp_id", 256'(rsp_id), 256'(o.id));
            chk("rsp_data", 256'(rsp_data), 256'(o.data));
         end
         chk("rsp_valid", 256'(rsp_valid), 256'(er));
         eg = 2'b00;
         if (!(m_cfg || cfg_we)) begin
            if (req_valid == 2'b01) eg = 2'b01;
            else if (req_valid == 2'b10) eg = 2'b10;
            else if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
         end
         chk("req_ready", 256'(req_ready), 256'(eg));
         if (eg != 2'b00) begin
            o.due = cyc + MM_LAT + 1;
            o.req = eg[1];
            o.id  = eg[1] ? req_id1 : req_id0;
            m_in1 = eg[1] ? req_a1 : req_a0;
            m_in2 = eg[1] ? req_b1 : req_b0;
            o.data = m_in1 ^ m_in2;
            exp_q.push_back(o);
            m_last = eg[1];
            m_last_due = o.due;
         end
         if (m_cfg && cyc == m_done) begin
            m_cfg = 0; m_mu = s_mu; m_p = s_p; m_np = s_np;
         end else if (!m_cfg && cfg_we) begin
            m_cfg = 1; s_mu = cfg_mu; s_p = cfg_p; s_np = cfg__p;
            m_done = (m_last_due + 1 > cyc + 2) ? m_last_due + 1 : cyc + 2;
         end
      end
   end

   typedef struct { logic [1:0] v; logic [1:0] r; } vec_t;
   vec_t tbl[16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int last_rsp, done_cyc;
      bit found;
      tbl = '{'{2'b11,2'b01}, '{2'b11,2'b10}, '{2'b11,2'b01}, '{2'b11,2'b10},
              '{2'b11,2'b01}, '{2'b11,2'b10}, '{2'b11,2'b01}, '{2'b11,2'b10},
              '{2'b01,2'b01}, '{2'b01,2'b01}, '{2'b01,2'b01}, '{2'b11,2'b10},
              '{2'b00,2'b00}, '{2'b10,2'b10}, '{2'b11,2'b01}, '{2'b00,2'b00}};
      rstn = 0; req_valid = 0; req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
      req_id0 = 0; req_id1 = 0; cfg_we = 0; cfg_mu = 0; cfg_p = 0; cfg__p = 0;
      repeat (3) step();
      rstn = 1;

      // arbitration table: contention, fairness after a solo run, idle gaps
      for (int i = 0; i < 16; i++) begin
         step();
         req_valid = tbl[i].v;
         req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
         req_id0 = 4'(i); req_id1 = 4'(i + 8);
         @(negedge clk);
         chk("table_ready", 256'(req_ready), 256'(tbl[i].r));
      end
      step(); req_valid = 0;
      repeat (10) step();

      // single request, result exactly MM_LAT+1 cycles later
      req_valid = 2'b01; req_a0 = 32'h12; req_b0 = 32'h34; req_id0 = 4'd3;
      @(negedge clk);
      chk("single_ready", 256'(req_ready), 256'(2'b01));
      step(); req_valid = 0;
      for (int k = 1; k <= MM_LAT; k++) begin
         @(negedge clk);
         chk("single_early", 256'(rsp_valid), 256'(0));
      end
      @(negedge clk);
      chk("single_valid", 256'(rsp_valid), 256'(2'b01));
      chk("single_data", 256'(rsp_data), 256'(32'h26));
      chk("single_id", 256'(rsp_id), 256'(4'd3));
      @(negedge clk);
      chk("single_after", 256'(rsp_valid), 256'(0));
      repeat (5) step();

      // reconfiguration with four operations in flight
      for (int i = 0; i < 4; i++) begin
         step();
         req_valid = 2'b01; req_a0 = $urandom; req_b0 = $urandom; req_id0 = 4'(i + 1);
      end
      step();
      cfg_we = 1; cfg_p = 32'h3001; cfg_mu = 32'h2FFF; cfg__p = 32'hFFFFCFFF;
      @(negedge clk);
      chk("cfg_blocks_req", 256'(req_ready), 256'(0));
      step(); cfg_we = 0;
      step(); cfg_we = 1; cfg_p = 32'hDEAD; cfg_mu = 32'hBEEF; cfg__p = 32'h1234;
      step(); cfg_we = 0;
      found = 0; last_rsp = 0; done_cyc = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (rsp_valid != 0) last_rsp = cyc;
         if (cfg_done) begin found = 1; done_cyc = cyc; end
      end
      chk("cfg_done_seen", 256'(found), 256'(1));
      chk("done_after_last_rsp", 256'(done_cyc - last_rsp), 256'(1));
      step(); req_valid = 0;
      @(negedge clk);
      chk("new_p", 256'(mm_p), 256'(32'h3001));
      chk("new_mu", 256'(mm_mu), 256'(32'h2FFF));
      chk("new_np", 256'(mm__p), 256'(32'hFFFFCFFF));
      repeat (10) step();

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         step();
         req_valid = 2'b10; req_a1 = $urandom; req_b1 = $urandom; req_id1 = 4'(i + 5);
      end
      step(); rstn = 0; req_valid = 2'b11;
      @(negedge clk);
      chk("rst_ready", 256'(req_ready), 256'(0));
      chk("rst_in1", 256'(mm_in1), 256'(0));
      chk("rst_p", 256'(mm_p), 256'(0));
      step(); step(); rstn = 1; req_valid = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("rst_no_rsp", 256'(rsp_valid), 256'(0));
      end
      step(); req_valid = 2'b11;
      @(negedge clk);
      chk("rst_first_grant", 256'(req_ready), 256'(2'b01));

      // randomized traffic with occasional reloads, checked by the model
      for (int i = 0; i < 400; i++) begin
         step();
         req_valid = 2'($urandom);
         req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
         req_id0 = 4'($urandom); req_id1 = 4'($urandom);
         cfg_we = ($urandom_range(0, 39) == 0);
         cfg_mu = $urandom; cfg_p = $urandom; cfg__p = $urandom;
      end
      step(); req_valid = 0; cfg_we = 0;
      repeat (20) step();
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mm_share_arb.md
Name: mm_share_arb

Overview:
- Shares one pipelined Montgomery modular multiplier between two requesters (the two butterfly units) in the NTT datapath.
- Arbitrates round-robin and registers the operands into the multiplier.
- Tracks each issued operation through the fixed multiplier latency and routes the result and the requester's tag back to the issuer.
- Owns the modulus constants (mu, p, _p) and reloads them only after the pipeline has drained.

Parameters:
- DW, 32: operand/result width; equals `datawidth.
- MM_LAT, 6: multiplier latency in cycles from mm_in1/mm_in2 to mm_out.
- ID_W, 4: width of the requester tag returned with each result.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester operation valid; bit i is requester i
- req_ready  out  2  per-requester accept
- req_a0, req_b0  in  DW each  requester 0 operands
- req_a1, req_b1  in  DW each  requester 1 operands
- req_id0, req_id1  in  ID_W each  requester tags
- mm_in1, mm_in2  out  DW each  registered operands to the multiplier
- mm_mu, mm_p, mm__p  out  DW each  held constants to the multiplier
- mm_out  in  DW  multiplier result
- rsp_valid  out  2  one-hot result strobe; bit i returns to requester i
- rsp_data  out  DW  result; equals mm_out
- rsp_id  out  ID_W  tag of the returned operation
- cfg_we  in  1  constant-load request
- cfg_mu, cfg_p, cfg__p  in  DW each  new constants
- cfg_busy  out  1  high while a load is pending
- cfg_done  out  1  one-cycle pulse when new constants take effect

Behaviour:
- Reset: all outputs 0, including the constant registers. FSM goes to RUN, the round-robin pointer prefers requester 0, in-flight tags clear. Reset mid-operation drops in-flight work: no rsp_valid until a new issue has completed.
- Arbitration (RUN only):
  - req_ready[i] = grant[i]; at most one bit is high.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the non-last-granted requester wins; the pointer updates only on a handshake.
  - ready does not depend on the next cycle; no stalls (the multiplier cannot stall).
- Issue: on handshake, the operands register into mm_in1/mm_in2 at the next edge (cycle T+1). When no issue occurs, mm_in1/mm_in2 hold their values.
- Tag pipeline:
  - An MM_LAT+1 deep shift register of {valid, requester index, id} advances every cycle.
  - Its output drives rsp_valid (one-hot), rsp_id and rsp_data=mm_out combinationally.
  - Result appears exactly MM_LAT+1 cycles after the handshake edge. Back-to-back issue gives one result per cycle.
  - Responses carry no backpressure; consumers must accept.
- In-flight counter: width clog2(MM_LAT+3). It increments on issue, decrements on rsp_valid, and takes no change on a simultaneous inc/dec. It never exceeds MM_LAT+1.
- FSM states: RUN, DRAIN, LOAD.
  - RUN: cfg_we=1 captures the cfg_* values into shadow registers and moves to DRAIN. req_ready is forced to 0 in that same cycle, so cfg_we beats a concurrent request.
  - DRAIN: req_ready=0. When the in-flight counter is 0, move to LOAD.
  - LOAD: one cycle. mm_mu/mm_p/mm__p take the shadow values at the exit edge, cfg_done=1 during that cycle, then return to RUN.
  - cfg_busy = (state != RUN).
  - cfg_we in DRAIN or LOAD is ignored; shadows are not overwritten.
- Constants are stable for every operation in flight; operations issued before a load use the old constants.
- Arithmetic: no computation in this block; widths pass straight through.

Test Plan:
- Bench multiplier model: mm_out = mm_in1 ^ mm_in2 delayed MM_LAT.
- Single request: requester 0 sends a=0x12, b=0x34, id=3 -> one handshake; rsp_valid=2'b01, rsp_data=0x26, rsp_id=3 exactly 7 cycles after the handshake; no other strobes.
- Contention: both valid continuously for 8 cycles -> grants alternate 0,1,0,1…; 8 results return in issue order, one per cycle, with the correct one-hot bit and ids.
- Fairness after an idle gap: requester 1 granted last, then only requester 0 requests for 3 cycles, then both -> requester 0 is served while alone; in the first contention cycle requester 1 wins only if requester 0 was granted last.
- Reconfig under load: cfg_we with p=0x3001, mu=0x2FFF, _p=0xFFFFCFFF while 4 ops are in flight -> req_ready=0 from that cycle; the 4 results return; cfg_done pulses one cycle after the last rsp_valid; mm_p=0x3001 from the next cycle; a cfg_we issued during DRAIN is ignored.
- Reset mid-flight: assert rstn=0 with 3 ops in flight -> all outputs 0 at once, no rsp_valid after release, arbiter grants requester 0 first.
